// File: rtl/alu_issue_if.sv
// Decoded-instruction handshake between decode and the operand-fetch/issue stage.
// The master drives the instruction fields; the slave answers with in_ready.
interface alu_issue_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_op;
  logic [AW-1:0]    in_rd;
  logic [AW-1:0]    in_rs;
  logic [AW-1:0]    in_rt;
  logic             in_use_imm;
  logic [WIDTH-1:0] in_imm;

  modport master (
    output in_valid, in_op, in_rd, in_rs, in_rt,
    output in_use_imm, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs, in_rt,
    input  in_use_imm, in_imm,
    output in_ready
  );
endinterface

// File: rtl/alu_issue.sv
// Operand fetch and issue stage feeding the combinational ALU.
// Holds the register file, bypasses the in-flight result, writes back one cycle later.
module alu_issue #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  alu_issue_if.slave               in_if,
  input  logic                     hold,
  output logic [4:0]               alu_op,
  output logic [WIDTH-1:0]         alu_x,
  output logic [WIDTH-1:0]         alu_y,
  input  logic [WIDTH-1:0]         alu_z,
  output logic                     out_valid,
  output logic [$clog2(NREGS)-1:0] out_rd,
  output logic [WIDTH-1:0]         out_result,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [WIDTH-1:0]         dbg_data
);

  localparam int AW = $clog2(NREGS);

  typedef enum logic {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } state_t;

  state_t           r_state;
  logic [AW-1:0]    r_iss_rd;
  logic [WIDTH-1:0] r_rf [NREGS];

  logic             w_iss_valid;
  logic             w_accept;
  logic             w_byp_s;
  logic             w_byp_t;
  logic [WIDTH-1:0] w_rf_s;
  logic [WIDTH-1:0] w_rf_t;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;

  assign w_iss_valid    = (r_state == BUSY);
  assign in_if.in_ready = !hold;
  assign w_accept       = in_if.in_valid && !hold;

  // r0 is never written, so reads of address 0 are forced to zero here
  assign w_rf_s = (in_if.in_rs == '0) ? '0 : r_rf[in_if.in_rs];
  assign w_rf_t = (in_if.in_rt == '0) ? '0 : r_rf[in_if.in_rt];

  assign w_byp_s = w_iss_valid && (r_iss_rd == in_if.in_rs)
                && (in_if.in_rs != '0);
  assign w_byp_t = w_iss_valid && (r_iss_rd == in_if.in_rt)
                && (in_if.in_rt != '0);

  assign w_x = w_byp_s ? alu_z : w_rf_s;
  assign w_y = in_if.in_use_imm ? in_if.in_imm
             : (w_byp_t ? alu_z : w_rf_t);

  assign dbg_data = (dbg_addr == '0) ? '0 : r_rf[dbg_addr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= EMPTY;
      r_iss_rd   <= '0;
      alu_op     <= '0;
      alu_x      <= '0;
      alu_y      <= '0;
      out_valid  <= 1'b0;
      out_rd     <= '0;
      out_result <= '0;
      for (int i = 0; i < NREGS; i++) begin
        r_rf[i] <= '0;
      end
    end else if (hold) begin
      out_valid <= 1'b0;
    end else begin
      if (w_iss_valid) begin
        if (r_iss_rd != '0) begin
          r_rf[r_iss_rd] <= alu_z;
        end
        out_valid  <= 1'b1;
        out_rd     <= r_iss_rd;
        out_result <= alu_z;
      end else begin
        out_valid <= 1'b0;
      end
      if (w_accept) begin
        r_state  <= BUSY;
        r_iss_rd <= in_if.in_rd;
        alu_op   <= in_if.in_op;
        alu_x    <= w_x;
        alu_y    <= w_y;
      end else begin
        r_state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with an adder stub standing in for the ALU.
// Vector table covers back-to-back issue/bypass; hand sequences cover hold and reset.
module tb_alu_issue;

  logic        clk;
  logic        reset_n;
  logic        hold;
  logic [4:0]  alu_op;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [15:0] alu_z;
  logic        out_valid;
  logic [3:0]  out_rd;
  logic [15:0] out_result;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_cmp;
  int n_bad;

  alu_issue_if #(.WIDTH(16), .AW(4)) bus ();

  alu_issue #(.WIDTH(16), .NREGS(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_if      (bus),
    .hold       (hold),
    .alu_op     (alu_op),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_z      (alu_z),
    .out_valid  (out_valid),
    .out_rd     (out_rd),
    .out_result (out_result),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  assign alu_z = alu_x + alu_y;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic        imm_en;
    logic [15:0] imm;
    logic [15:0] ex_x;
    logic [15:0] ex_y;
    logic [15:0] ex_z;
  } vec_t;

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
  } reg_t;

  vec_t vecs [8];
  reg_t regs [9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid   = 1'b1;
    bus.in_op      = v.op;
    bus.in_rd      = v.rd;
    bus.in_rs      = v.rs;
    bus.in_rt      = v.rt;
    bus.in_use_imm = v.imm_en;
    bus.in_imm     = v.imm;
  endtask

  task automatic idle();
    bus.in_valid   = 1'b0;
    bus.in_op      = 5'h1e;
    bus.in_rd      = 4'hf;
    bus.in_rs      = 4'hf;
    bus.in_rt      = 4'hf;
    bus.in_use_imm = 1'b0;
    bus.in_imm     = 16'hdead;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    //      op     rd    rs    rt    imm   immv      x        y        z
    vecs[0] = '{5'h03, 4'd1, 4'd0, 4'd0, 1'b1, 16'h0005, 16'h0000, 16'h0005, 16'h0005};
    vecs[1] = '{5'h07, 4'd2, 4'd1, 4'd0, 1'b1, 16'h0003, 16'h0005, 16'h0003, 16'h0008};
    vecs[2] = '{5'h1f, 4'd3, 4'd2, 4'd2, 1'b0, 16'hbeef, 16'h0008, 16'h0008, 16'h0010};
    vecs[3] = '{5'h01, 4'd0, 4'd0, 4'd0, 1'b1, 16'h1234, 16'h0000, 16'h1234, 16'h1234};
    vecs[4] = '{5'h10, 4'd7, 4'd0, 4'd3, 1'b0, 16'h0000, 16'h0000, 16'h0010, 16'h0010};
    vecs[5] = '{5'h0a, 4'd5, 4'd0, 4'd0, 1'b1, 16'hffff, 16'h0000, 16'hffff, 16'hffff};
    vecs[6] = '{5'h15, 4'd6, 4'd5, 4'd0, 1'b1, 16'h0001, 16'hffff, 16'h0001, 16'h0000};
    vecs[7] = '{5'h00, 4'd8, 4'd6, 4'd5, 1'b0, 16'h0000, 16'h0000, 16'hffff, 16'hffff};

    regs[0] = '{4'd0, 16'h0000};
    regs[1] = '{4'd1, 16'h0005};
    regs[2] = '{4'd2, 16'h0008};
    regs[3] = '{4'd3, 16'h0010};
    regs[4] = '{4'd4, 16'h0000};
    regs[5] = '{4'd5, 16'hffff};
    regs[6] = '{4'd6, 16'h0000};
    regs[7] = '{4'd7, 16'h0010};
    regs[8] = '{4'd8, 16'hffff};

    hold     = 1'b0;
    dbg_addr = 4'd0;
    idle();
    reset_n  = 1'b0;
    #12;
    chk("rst_alu_x", alu_x, 16'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_rd", out_rd, 4'h0);
    reset_n = 1'b1;
    step();
    chk("rst_in_ready", bus.in_ready, 1'b1);

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i]);
      step();
      chk($sformatf("v%0d_op", i), alu_op, vecs[i].op);
      chk($sformatf("v%0d_x", i), alu_x, vecs[i].ex_x);
      chk($sformatf("v%0d_y", i), alu_y, vecs[i].ex_y);
      if (i > 0) begin
        chk($sformatf("v%0d_ov", i), out_valid, 1'b1);
        chk($sformatf("v%0d_ord", i), out_rd, vecs[i-1].rd);
        chk($sformatf("v%0d_ores", i), out_result, vecs[i-1].ex_z);
      end else begin
        chk("v0_ov", out_valid, 1'b0);
      end
    end
    idle();
    step();
    chk("tail_ov", out_valid, 1'b1);
    chk("tail_ord", out_rd, 4'd8);
    chk("tail_ores", out_result, 16'hffff);
    step();
    chk("tail_ov_drop", out_valid, 1'b0);
    chk("tail_ores_hold", out_result, 16'hffff);

    for (int i = 0; i < 9; i++) begin
      dbg_addr = regs[i].a;
      #1;
      chk($sformatf("dbg_r%0d", regs[i].a), dbg_data, regs[i].d);
    end

    // hold during BUSY: operands frozen, exactly one writeback on release
    drive('{5'h04, 4'd4, 4'd1, 4'd0, 1'b1, 16'h0001, 16'h0, 16'h0, 16'h0});
    step();
    chk("h_x", alu_x, 16'h0005);
    chk("h_y", alu_y, 16'h0001);
    hold = 1'b1;
    drive('{5'h09, 4'd9, 4'd3, 4'd0, 1'b1, 16'h0100, 16'h0, 16'h0, 16'h0});
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("h%0d_rdy", c), bus.in_ready, 1'b0);
      step();
      chk($sformatf("h%0d_ov", c), out_valid, 1'b0);
      chk($sformatf("h%0d_x", c), alu_x, 16'h0005);
      chk($sformatf("h%0d_y", c), alu_y, 16'h0001);
      chk($sformatf("h%0d_op", c), alu_op, 5'h04);
    end
    hold = 1'b0;
    idle();
    step();
    chk("hrel_ov", out_valid, 1'b1);
    chk("hrel_ord", out_rd, 4'd4);
    chk("hrel_ores", out_result, 16'h0006);
    step();
    chk("hrel_once", out_valid, 1'b0);
    dbg_addr = 4'd4;
    #1;
    chk("dbg_r4_hold", dbg_data, 16'h0006);
    dbg_addr = 4'd9;
    #1;
    chk("dbg_r9_noacc", dbg_data, 16'h0000);

    // async reset with an instruction in flight
    drive('{5'h0c, 4'd9, 4'd1, 4'd0, 1'b1, 16'h0002, 16'h0, 16'h0, 16'h0});
    step();
    chk("r_pre_x", alu_x, 16'h0005);
    idle();
    #2;
    reset_n = 1'b0;
    #1;
    chk("ra_op", alu_op, 5'h0);
    chk("ra_x", alu_x, 16'h0);
    chk("ra_y", alu_y, 16'h0);
    chk("ra_ov", out_valid, 1'b0);
    chk("ra_ord", out_rd, 4'h0);
    chk("ra_ores", out_result, 16'h0);
    for (int a = 0; a < 16; a++) begin
      dbg_addr = 4'(a);
      #1;
      chk($sformatf("ra_dbg%0d", a), dbg_data, 16'h0);
    end
    #3;
    reset_n = 1'b1;
    step();
    chk("rr_rdy", bus.in_ready, 1'b1);
    chk("rr_ov", out_valid, 1'b0);
    step();
    chk("rr_ov2", out_valid, 1'b0);
    dbg_addr = 4'd9;
    #1;
    chk("rr_r9", dbg_data, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Operand-fetch and issue stage directly upstream of the `alu` block. It holds the 16-entry general register file and accepts one decoded instruction per cycle. It reads operands, with a bypass from the in-flight result, and presents registered `ALUop`/X/Y to the combinational ALU. It captures the ALU result one cycle later and writes it back to the register file. It is the first stateful piece of the execute path and the unit the ALU plugs into for full-datapath benches.

## Interface
- `WIDTH`, 16: data word width; matches `` `WORD``.
- `NREGS`, 16: register count; register address width is log2(NREGS) = 4.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  decoded instruction present on the `in_*` inputs.
- `in_ready`  out  1  stage can accept an instruction; equals `!hold`.
- `in_op`  in  5  ALU operation code, passed through unchanged.
- `in_rd`, `in_rs`, `in_rt`  in  4 each  destination register, X-source register, Y-source register.
- `in_use_imm`  in  1  when 1, Y comes from `in_imm` instead of register `in_rt`.
- `in_imm`  in  WIDTH  immediate operand.
- `hold`  in  1  freezes the issue stage: no accept, no writeback.
- `alu_op`  out  5  registered; drives the ALU `ALUop` input.
- `alu_x`, `alu_y`  out  WIDTH  registered operands; drive the ALU X and Y inputs.
- `alu_z`  in  WIDTH  combinational ALU result for the issued operands.
- `out_valid`  out  1  registered pulse: a writeback occurred on the last edge.
- `out_rd`  out  4  destination of the last writeback.
- `out_result`  out  WIDTH  value of the last writeback.
- `dbg_addr`  in  4  asynchronous register-file read port for benches.
- `dbg_data`  out  WIDTH  contents of register `dbg_addr`; r0 always reads 0.

## Operation
- **Register file:** NREGS×WIDTH flops. r0 is hardwired to zero: reads return 0 and writes are discarded.
- **Issue register:** holds `iss_valid`, `iss_rd`, `alu_op`, `alu_x`, `alu_y`.
- **Accept:** an instruction is accepted on an edge where `in_valid && in_ready`.
  - The issue register loads the operands.
  - X = read(`in_rs`).
  - Y = `in_use_imm` ? `in_imm` : read(`in_rt`).
- **Bypass:** read(a) returns `alu_z` when `iss_valid && iss_rd == a && a != 0`. Otherwise it returns the register-file contents.
- **Writeback:** on every edge where `iss_valid && !hold`:
  - `alu_z` is written to reg[`iss_rd`], unless `iss_rd` is 0.
  - `out_valid` <= 1, `out_rd` <= `iss_rd`, `out_result` <= `alu_z`. Reporting happens even when `iss_rd` is 0.
- **Out pulse:** on other edges `out_valid` <= 0; `out_rd` and `out_result` hold their values.
- **Issue stage with `!hold`, no accept:** `iss_valid` <= 0; `alu_op`, `alu_x`, `alu_y` hold their last values.
- **Issue stage with `hold`:** the issue register and register file are unchanged and `in_ready` = 0.
- **Arithmetic:** none in this block. `alu_z` is taken as WIDTH bits with no extension or truncation.
- **State machine:** two states encoded by `iss_valid`: EMPTY and BUSY.
  - EMPTY → BUSY on accept.
  - BUSY → BUSY on accept, which also writes back.
  - BUSY → EMPTY on no accept with `!hold`.
  - `hold` keeps the current state.

## Timing
- **Reset:** asynchronous assertion clears the following immediately, independent of `clk`:
  - all registers and `iss_valid`
  - `alu_op`, `alu_x`, `alu_y`
  - `out_valid`, `out_rd`, `out_result`
- **Reset mid-operation:** any in-flight instruction is dropped with no writeback.
- **Deassertion:** takes effect at the next rising edge; `in_ready` = 1 then if `hold` = 0.
- **Latency:**
  - accept at edge N
  - `alu_*` valid after edge N
  - writeback and `out_valid` at edge N+1
- **Throughput:** one instruction per cycle.
- **Back-to-back dependency:** a dependent instruction accepted at edge N+1 sees the result through the bypass. There is no stall.
- **Simultaneous accept and writeback:** the writeback to reg[rd] and the bypass read of the same rd occur on the same edge; the bypass value wins.
- **`hold` during BUSY:** `alu_x`, `alu_y`, `alu_op` stay stable for the whole hold. Exactly one writeback occurs on the first edge after `hold` falls.

## Test plan
The bench drives `alu_z = alu_x + alu_y` truncated to 16 bits (adder stub). It checks that `alu_op` matches `in_op` after every accept.
- **Reset:** assert `reset_n` = 0 mid-stream → all outputs 0 asynchronously; `dbg_data` reads 0 for every address; no `out_valid` after release.
- **Immediate load:** r1 ← r0 + imm 0x0005 → `alu_x` = 0x0000, `alu_y` = 0x0005 one edge later; next edge `out_valid` = 1, `out_rd` = 1, `out_result` = 0x0005; dbg r1 = 0x0005.
- **Back-to-back bypass:** r2 ← r1 + imm 0x0003, then immediately r3 ← r2 + r2 → second issue shows `alu_x` = `alu_y` = 0x0008; r3 = 0x0010.
- **r0 write:** rd = 0, imm 0x1234 → `out_valid` = 1, `out_rd` = 0, `out_result` = 0x1234; dbg r0 = 0. A following instruction reading r0 gets `alu_x` = 0 with no bypass.
- **Hold:** issue r4 ← r1 + imm 1, then `hold` = 1 for 3 cycles → `in_ready` = 0, operands stable, `out_valid` = 0. Release → one `out_valid` pulse, r4 = 0x0006.
- **Wrap-around:** r5 ← r0 + imm 0xFFFF, then r6 ← r5 + imm 0x0001 → r6 = 0x0000 via bypass, r5 = 0xFFFF.
